// File: rtl/burst_ram_arbiter.sv
// Two-client round-robin arbiter in front of a single BurstRAM port.
// Requests are captured per client; write beats are buffered so the RAM always sees a contiguous burst.
module burst_ram_arbiter #(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic                                 c0_cmd,
    input  logic                                 c0_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        c0_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   c0_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] c0_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   c0_rd_data,
    output logic                                 c0_rd_data_valid,
    output logic                                 c0_busy,

    input  logic                                 c1_cmd,
    input  logic                                 c1_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        c1_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   c1_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] c1_data_mask,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   c1_rd_data,
    output logic                                 c1_rd_data_valid,
    output logic                                 c1_busy,

    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy
);

    localparam int AW = RAM_DEPTH_BITWIDTH;
    localparam int DW = RAM_BURST_DATA_BITWIDTH;
    localparam int MW = RAM_BURST_DATA_BITWIDTH / 8;
    localparam int NB = RAM_BURST_DATA_COUNT;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(NB + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WR_BEATS,
        S_RD_WAIT
    } state_t;

    logic [1:0]    w_cmd_en;
    logic [1:0]    w_cmd;
    logic [AW-1:0] w_addr    [2];
    logic [DW-1:0] w_wr_data [2];
    logic [MW-1:0] w_mask    [2];

    assign w_cmd_en     = {c1_cmd_en, c0_cmd_en};
    assign w_cmd        = {c1_cmd, c0_cmd};
    assign w_addr[0]    = c0_addr;
    assign w_addr[1]    = c1_addr;
    assign w_wr_data[0] = c0_wr_data;
    assign w_wr_data[1] = c1_wr_data;
    assign w_mask[0]    = c0_data_mask;
    assign w_mask[1]    = c1_data_mask;

    logic [1:0]    r_pending;
    logic [1:0]    r_cmd;
    logic [1:0]    r_rd_valid;
    logic [AW-1:0] r_addr    [2];
    logic [CW-1:0] r_cap_cnt [2];
    logic [DW-1:0] r_rd_data [2];
    logic [DW-1:0] r_wbuf    [2][NB];
    logic [MW-1:0] r_wmask   [2][NB];

    state_t        r_state;
    state_t        w_next_state;
    logic          r_owner;
    logic          r_last;
    logic [BW-1:0] r_beat;

    logic [1:0]    w_accept;
    logic [1:0]    w_cap_beat;
    logic [1:0]    w_elig;
    logic          w_grant;
    logic          w_grant_en;
    logic          w_done;
    logic          w_fwd;

    // A write becomes eligible only once its capture counter has seen every beat.
    always_comb begin
        w_accept   = '0;
        w_cap_beat = '0;
        w_elig     = '0;
        for (int n = 0; n < 2; n++) begin
            w_accept[n]   = w_cmd_en[n] & ~r_pending[n];
            w_cap_beat[n] = r_pending[n] & r_cmd[n] & (r_cap_cnt[n] != FULL_CNT);
            w_elig[n]     = r_pending[n] & (~r_cmd[n] | (r_cap_cnt[n] == FULL_CNT));
        end
    end

    assign w_grant = (&w_elig) ? ~r_last : w_elig[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_cmd      <= '0;
            r_rd_valid <= '0;
            for (int n = 0; n < 2; n++) begin
                r_addr[n]    <= '0;
                r_cap_cnt[n] <= '0;
                r_rd_data[n] <= '0;
            end
        end else begin
            r_rd_valid <= '0;
            for (int n = 0; n < 2; n++) begin
                if (w_accept[n]) begin
                    r_pending[n] <= 1'b1;
                    r_cmd[n]     <= w_cmd[n];
                    r_addr[n]    <= w_addr[n];
                    r_cap_cnt[n] <= w_cmd[n] ? CW'(1) : '0;
                end else if (w_cap_beat[n]) begin
                    r_cap_cnt[n] <= r_cap_cnt[n] + CW'(1);
                end
                if (w_done && (r_owner == 1'(n))) begin
                    r_pending[n] <= 1'b0;
                    r_cap_cnt[n] <= '0;
                end
                if (w_fwd && (r_owner == 1'(n))) begin
                    r_rd_data[n]  <= br_rd_data;
                    r_rd_valid[n] <= 1'b1;
                end
            end
        end
    end

    // NOTE: the beat buffers are deliberately not reset; r_cap_cnt gates eligibility, so stale contents are never issued.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (w_accept[n] && w_cmd[n]) begin
                r_wbuf[n][0]  <= w_wr_data[n];
                r_wmask[n][0] <= w_mask[n];
            end else if (w_cap_beat[n]) begin
                r_wbuf[n][r_cap_cnt[n][BW-1:0]]  <= w_wr_data[n];
                r_wmask[n][r_cap_cnt[n][BW-1:0]] <= w_mask[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_beat  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_en) begin
                r_owner <= w_grant;
                r_last  <= w_grant;
                r_beat  <= '0;
            end
            if (r_state == S_ISSUE) begin
                r_beat <= r_cmd[r_owner] ? BW'(1) : '0;
            end else if ((r_state == S_WR_BEATS) || w_fwd) begin
                r_beat <= r_beat + BW'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_en   = 1'b0;
        w_done       = 1'b0;
        w_fwd        = 1'b0;
        br_cmd       = 1'b0;
        br_cmd_en    = 1'b0;
        br_addr      = '0;
        br_wr_data   = '0;
        br_data_mask = '0;
        unique case (r_state)
            S_IDLE: begin
                if ((|w_elig) && !br_busy) begin
                    w_grant_en   = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                br_cmd_en = 1'b1;
                br_cmd    = r_cmd[r_owner];
                br_addr   = r_addr[r_owner];
                if (r_cmd[r_owner]) begin
                    br_wr_data   = r_wbuf[r_owner][0];
                    br_data_mask = r_wmask[r_owner][0];
                    w_next_state = S_WR_BEATS;
                end else begin
                    w_next_state = S_RD_WAIT;
                end
            end
            S_WR_BEATS: begin
                br_cmd       = 1'b1;
                br_addr      = r_addr[r_owner];
                br_wr_data   = r_wbuf[r_owner][r_beat];
                br_data_mask = r_wmask[r_owner][r_beat];
                if (r_beat == LAST_BEAT) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (br_rd_data_valid) begin
                    w_fwd = 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_done       = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign c0_busy          = r_pending[0];
    assign c1_busy          = r_pending[1];
    assign c0_rd_data       = r_rd_data[0];
    assign c1_rd_data       = r_rd_data[1];
    assign c0_rd_data_valid = r_rd_valid[0];
    assign c1_rd_data_valid = r_rd_valid[1];

endmodule
